// File: rtl/winograd_pkg.sv
// Shared types for the Winograd tile arbiter: element width, tile/kernel/result
// array shapes and the arbiter FSM state encoding.
package winograd_pkg;

  localparam int WG_DATA_W = 16;

  typedef logic [5:0][5:0][WG_DATA_W-1:0] tile6_t;
  typedef logic [2:0][2:0][WG_DATA_W-1:0] kern3_t;
  typedef logic [3:0][3:0][WG_DATA_W-1:0] res4_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/winograd_tile_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit at or after ptr_i,
// searching cyclically. Returns one-hot grant, its index and an any-request flag.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic found;
  int   j;

  // Walk the requesters starting at ptr_i and take the first one that is set.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/winograd_tile_arbiter.sv
// Shares one Winograd F(4x4,3x3) tile engine among NUM_REQ requesters.
// One job at a time, round-robin order, payload latched on grant, and a
// watchdog that aborts a job that sits in ST_WAIT for TIMEOUT cycles.
module winograd_tile_arbiter
  import winograd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = WG_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_REQ-1:0]                       req_i,
  input  logic [NUM_REQ-1:0][5:0][5:0][DATA_W-1:0] req_tile_i,
  input  logic [NUM_REQ-1:0][2:0][2:0][DATA_W-1:0] req_kernel_i,
  output logic [NUM_REQ-1:0]                       grant_o,
  output logic [NUM_REQ-1:0]                       rsp_valid_o,
  output logic                                     rsp_err_o,
  output logic [3:0][3:0][DATA_W-1:0]              rsp_result_o,
  output logic                                     busy_o,
  output logic                                     err_sticky_o,
  output logic                                     eng_start_o,
  output logic [5:0][5:0][DATA_W-1:0]              eng_tile_o,
  output logic [2:0][2:0][DATA_W-1:0]              eng_kernel_o,
  input  logic [3:0][3:0][DATA_W-1:0]              eng_result_i,
  input  logic                                     eng_done_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so the watchdog compare never sees a wrapped value.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_t                     state_q;
  logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]               k_q;
  logic [NUM_REQ-1:0]             k_oh_q;
  logic [CNT_W-1:0]               wd_cnt_q;
  logic [NUM_REQ-1:0]             grant_q, rsp_valid_q;
  logic                           rsp_err_q, busy_q, err_sticky_q, eng_start_q;
  logic [3:0][3:0][DATA_W-1:0]    rsp_result_q;
  logic [5:0][5:0][DATA_W-1:0]    eng_tile_q;
  logic [2:0][2:0][DATA_W-1:0]    eng_kernel_q;

  logic [NUM_REQ-1:0]             pick_gnt;
  logic [IDX_W-1:0]               pick_idx;
  logic                           pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Pointer moves to the requester just after the one being served.
  always_comb begin
    rr_ptr_d = k_q + IDX_W'(1);
    if (k_q == IDX_W'(NUM_REQ - 1)) rr_ptr_d = '0;
  end

  // Arbiter FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      k_q          <= '0;
      k_oh_q       <= '0;
      wd_cnt_q     <= '0;
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_tile_q   <= '0;
      eng_kernel_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            k_q          <= pick_idx;
            k_oh_q       <= pick_gnt;
            grant_q      <= pick_gnt;
            eng_tile_q   <= req_tile_i[pick_idx];
            eng_kernel_q <= req_kernel_i[pick_idx];
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          grant_q     <= '0;
          eng_start_q <= 1'b1;
          wd_cnt_q    <= '0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Response registers load here so rsp_valid lands in ST_RESP,
          // one cycle after eng_done.
          eng_start_q <= 1'b0;
          wd_cnt_q    <= wd_cnt_q + CNT_W'(1);
          if (eng_done_i) begin
            rsp_valid_q  <= k_oh_q;
            rsp_result_q <= eng_result_i;
            rsp_err_q    <= 1'b0;
            state_q      <= ST_RESP;
          end else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid_q  <= k_oh_q;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= '0;
          rr_ptr_q    <= rr_ptr_d;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_result_o = rsp_result_q;
  assign busy_o       = busy_q;
  assign err_sticky_o = err_sticky_q;
  assign eng_start_o  = eng_start_q;
  assign eng_tile_o   = eng_tile_q;
  assign eng_kernel_o = eng_kernel_q;

endmodule

// File: tb/tb_winograd_tile_arbiter.sv
// Directed bench for winograd_tile_arbiter with a behavioural engine that
// answers 8 cycles after start with a direct 3x3 correlation of the latched tile.
module tb_winograd_tile_arbiter;
  import winograd_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic [NR-1:0]                     req;
  logic [NR-1:0][5:0][5:0][DW-1:0]   req_tile;
  logic [NR-1:0][2:0][2:0][DW-1:0]   req_kernel;
  logic [NR-1:0]                     grant, rsp_valid;
  logic                              rsp_err, busy, err_sticky, eng_start, eng_done;
  res4_t                             rsp_result, eng_result;
  tile6_t                            eng_tile;
  kern3_t                            eng_kernel;

  int n_chk = 0;
  int n_err = 0;

  winograd_tile_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .req_tile_i   (req_tile),
    .req_kernel_i (req_kernel),
    .grant_o      (grant),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .rsp_result_o (rsp_result),
    .busy_o       (busy),
    .err_sticky_o (err_sticky),
    .eng_start_o  (eng_start),
    .eng_tile_o   (eng_tile),
    .eng_kernel_o (eng_kernel),
    .eng_result_i (eng_result),
    .eng_done_i   (eng_done)
  );

  always #5 clk = ~clk;

  // ---------------- engine model ----------------
  logic       mute;
  logic       done_inj;
  logic       done_q;
  logic [3:0] cnt_q;
  res4_t      res_q;

  function automatic res4_t conv(input tile6_t t, input kern3_t k);
    res4_t         r;
    logic [DW-1:0] acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            acc = acc + DW'(t[i+a][j+b] * k[a][b]);
        r[i][j] = acc;
      end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (eng_start && !mute) cnt_q <= 4'd8;
      else if (cnt_q != 0) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          done_q <= 1'b1;
          res_q  <= conv(eng_tile, eng_kernel);
        end
      end
    end
  end

  assign eng_done   = done_q | done_inj;
  assign eng_result = res_q;

  // ---------------- payload helpers ----------------
  function automatic tile6_t tile_fill(input logic [DW-1:0] v);
    tile6_t t;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) t[r][c] = v;
    return t;
  endfunction

  function automatic tile6_t tile_ramp();
    tile6_t t;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) t[r][c] = DW'(r * 6 + c);
    return t;
  endfunction

  function automatic kern3_t kern_fill(input logic [DW-1:0] v);
    kern3_t k;
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) k[a][b] = v;
    return k;
  endfunction

  function automatic kern3_t kern_center();
    kern3_t k;
    k = '0;
    k[1][1] = DW'(1);
    return k;
  endfunction

  function automatic kern3_t kern_corner2();
    kern3_t k;
    k = '0;
    k[0][0] = DW'(2);
    return k;
  endfunction

  function automatic res4_t res_fill(input logic [DW-1:0] v);
    res4_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = v;
    return r;
  endfunction

  // Ramp tile through the centre tap: out[i][j] = tile[i+1][j+1]
  function automatic res4_t res_ramp();
    res4_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = DW'((i + 1) * 6 + (j + 1));
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one job from the current IDLE cycle to the IDLE cycle after RESP.
  // clr drops those req bits right after the grant; corrupt also scribbles their payload.
  task automatic do_job(input string tag, input logic [NR-1:0] exp_g, input logic [NR-1:0] clr,
                        input logic corrupt, input res4_t exp_res, input logic exp_err,
                        input int exp_lat);
    int n, starts, lat;
    n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".grant"}, grant, exp_g);
    chk({tag, ".busy"}, busy, 1'b1);
    req = req & ~clr;
    if (corrupt)
      for (int r = 0; r < NR; r++)
        if (clr[r]) begin
          req_tile[r]   = '1;
          req_kernel[r] = '1;
        end
    starts = 0;
    lat    = -1;
    n      = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (eng_start) begin
        starts++;
        lat = 0;
      end else if (lat >= 0) lat++;
      if (rsp_valid != '0) break;
    end
    chk({tag, ".starts"}, starts, 1);
    chk({tag, ".rsp_valid"}, rsp_valid, exp_g);
    chk({tag, ".rsp_result"}, rsp_result, exp_res);
    chk({tag, ".rsp_err"}, rsp_err, exp_err);
    chk({tag, ".latency"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, ".rsp_drop"}, rsp_valid, '0);
    chk({tag, ".idle_gap"}, busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req        = '0;
    req_tile   = '0;
    req_kernel = '0;
    mute       = 1'b0;
    done_inj   = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.grant", grant, '0);
    chk("rst.rsp_valid", rsp_valid, '0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.err_sticky", err_sticky, 1'b0);
    chk("rst.eng_start", eng_start, 1'b0);
    chk("rst.eng_tile", eng_tile == '0, 1'b1);
    chk("rst.eng_kernel", eng_kernel == '0, 1'b1);
    chk("rst.rsp_result", rsp_result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single request, identity kernel
    req_tile[1]   = tile_fill(DW'(1));
    req_kernel[1] = kern_center();
    req           = 4'b0010;
    do_job("t1", 4'b0010, 4'b0010, 1'b0, res_fill(DW'(1)), 1'b0, 10);

    // eng_done outside ST_WAIT must be ignored
    done_inj = 1'b1;
    @(negedge clk);
    done_inj = 1'b0;
    @(negedge clk);
    chk("stray_done.rsp_valid", rsp_valid, '0);
    chk("stray_done.busy", busy, 1'b0);

    // 2: all four held from reset -> 0,1,2,3,0
    do_reset();
    req_tile[0] = tile_fill(DW'(1)); req_kernel[0] = kern_fill(DW'(1));
    req_tile[1] = tile_ramp();       req_kernel[1] = kern_center();
    req_tile[2] = tile_fill(DW'(2)); req_kernel[2] = kern_center();
    req_tile[3] = tile_fill(DW'(3)); req_kernel[3] = kern_corner2();
    req = 4'b1111;
    do_job("t2.j0", 4'b0001, '0, 1'b0, res_fill(DW'(9)), 1'b0, 10);
    do_job("t2.j1", 4'b0010, '0, 1'b0, res_ramp(),       1'b0, 10);
    do_job("t2.j2", 4'b0100, '0, 1'b0, res_fill(DW'(2)), 1'b0, 10);
    do_job("t2.j3", 4'b1000, '0, 1'b0, res_fill(DW'(6)), 1'b0, 10);
    do_job("t2.j4", 4'b0001, '0, 1'b0, res_fill(DW'(9)), 1'b0, 10);
    req = '0;

    // 3: req0 held, req2 joins at the 2nd job -> 0,2,0,2
    do_reset();
    req = 4'b0001;
    do_job("t3.j0", 4'b0001, '0, 1'b0, res_fill(DW'(9)), 1'b0, 10);
    req = 4'b0101;
    do_job("t3.j1", 4'b0100, '0, 1'b0, res_fill(DW'(2)), 1'b0, 10);
    do_job("t3.j2", 4'b0001, '0, 1'b0, res_fill(DW'(9)), 1'b0, 10);
    do_job("t3.j3", 4'b0100, '0, 1'b0, res_fill(DW'(2)), 1'b0, 10);
    req = '0;

    // 4: watchdog abort, then a normal job with err_sticky still set
    do_reset();
    mute = 1'b1;
    req  = 4'b0001;
    do_job("t4.to", 4'b0001, 4'b0001, 1'b0, res_fill(DW'(0)), 1'b1, TO);
    chk("t4.sticky_set", err_sticky, 1'b1);
    mute = 1'b0;
    req  = 4'b0001;
    do_job("t4.ok", 4'b0001, 4'b0001, 1'b0, res_fill(DW'(9)), 1'b0, 10);
    chk("t4.sticky_hold", err_sticky, 1'b1);

    // 5: reset mid-job, rr_ptr (now 1) must return to 0
    req = 4'b0001;
    begin
      int n;
      n = 0;
      while (grant == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("t5.busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5.busy", busy, 1'b0);
    chk("t5.err_sticky", err_sticky, 1'b0);
    chk("t5.grant", grant, '0);
    chk("t5.rsp_valid", rsp_valid, '0);
    chk("t5.eng_start", eng_start, 1'b0);
    chk("t5.eng_tile", eng_tile == '0, 1'b1);
    chk("t5.rsp_result", rsp_result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b0101;
    do_job("t5.j0", 4'b0001, 4'b0001, 1'b0, res_fill(DW'(9)), 1'b0, 10);
    do_job("t5.j1", 4'b0100, 4'b0100, 1'b0, res_fill(DW'(2)), 1'b0, 10);

    // 6: req1 dropped and payload overwritten right after grant
    req_tile[1]   = tile_ramp();
    req_kernel[1] = kern_center();
    req           = 4'b0010;
    do_job("t6", 4'b0010, 4'b0010, 1'b1, res_ramp(), 1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
